// File: rtl/ptw_mem_responder.sv
// Memory-side responder for the PTW: word-read requests served from an internal
// page-table RAM after LATENCY cycles. Define PTW_MEM_STATS_EN for traffic counters.
module ptw_mem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_req_valid_i,
    output logic        mem_req_ready_o,
    input  logic [31:0] mem_addr_i,
    output logic        mem_resp_valid_o,
    input  logic        mem_resp_ready_i,
    output logic [31:0] mem_data_o,
    output logic        mem_err_o,
    input  logic        init_we_i,
    input  logic [31:0] init_addr_i,
    input  logic [31:0] init_data_i
`ifdef PTW_MEM_STATS_EN
    ,
    output logic [15:0] req_count_o,
    output logic [15:0] err_count_o,
    output logic [15:0] stall_count_o
`endif
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [29:0] DEPTH_IDX = 30'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e        state_q;
    logic [3:0]    cnt_q;
    logic [AW-1:0] idx_q;
    logic          in_range_q;
    logic          ready_q;
    logic          valid_q;
    logic [31:0]   data_q;
    logic          err_q;

    logic [31:0]   mem [DEPTH];

    logic [AW-1:0] req_idx;
    logic          req_in_range;
    logic [AW-1:0] init_idx;
    logic          init_in_range;
    logic [AW-1:0] rd_idx;
    logic          rd_in_range;
    logic [31:0]   rd_data_d;
    logic          req_fire;
    logic          unused_addr_bits;

    assign req_idx          = mem_addr_i[AW+1:2];
    assign req_in_range     = (mem_addr_i[31:2] < DEPTH_IDX);
    assign init_idx         = init_addr_i[AW+1:2];
    assign init_in_range    = (init_addr_i[31:2] < DEPTH_IDX);
    assign req_fire         = ready_q && mem_req_valid_i;
    assign unused_addr_bits = ^{mem_addr_i[1:0], init_addr_i[1:0]};

    // With LATENCY=1 the read happens on the handshake cycle itself, so the
    // index comes straight from the request rather than the latched copy.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        rd_idx      = idx_q;
        rd_in_range = in_range_q;
        if (LATENCY == 1) begin
            rd_idx      = req_idx;
            rd_in_range = req_in_range;
        end
    end

    // Write-first: a same-cycle preload to the word being read wins.
    always_comb begin
        rd_data_d = '0;
        if (rd_in_range) begin
            if (init_we_i && init_in_range && (init_idx == rd_idx)) begin
                rd_data_d = init_data_i;
            end else begin
                rd_data_d = mem[rd_idx];
            end
        end
    end

    // NOTE: the RAM array has no reset so contents survive rst and map onto block/distributed RAM.
    always_ff @(posedge clk) begin
        if (init_we_i && init_in_range) begin
            mem[init_idx] <= init_data_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, avoiding read/write races between blocks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            in_range_q <= 1'b0;
            ready_q    <= 1'b0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_fire) begin
                        ready_q    <= 1'b0;
                        idx_q      <= req_idx;
                        in_range_q <= req_in_range;
                        cnt_q      <= 4'(LATENCY - 1);
                        if (LATENCY == 1) begin
                            state_q <= S_RESP;
                            valid_q <= 1'b1;
                            data_q  <= rd_data_d;
                            err_q   <= !rd_in_range;
                        end else begin
                            state_q <= S_WAIT;
                        end
                    end else begin
                        // First IDLE cycle after a response or reset is the bubble.
                        ready_q <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd1) begin
                        cnt_q   <= '0;
                        state_q <= S_RESP;
                        valid_q <= 1'b1;
                        data_q  <= rd_data_d;
                        err_q   <= !rd_in_range;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_RESP: begin
                    if (mem_resp_ready_i) begin
                        valid_q <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_req_ready_o  = ready_q;
    assign mem_resp_valid_o = valid_q;
    assign mem_data_o       = data_q;
    assign mem_err_o        = err_q;

`ifdef PTW_MEM_STATS_EN
    logic [15:0] req_cnt_q;
    logic [15:0] err_cnt_q;
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_cnt_q   <= '0;
            err_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (req_fire && (req_cnt_q != 16'hFFFF)) begin
                req_cnt_q <= req_cnt_q + 16'd1;
            end
            if (valid_q && mem_resp_ready_i && err_q && (err_cnt_q != 16'hFFFF)) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
            if (valid_q && !mem_resp_ready_i && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    assign req_count_o   = req_cnt_q;
    assign err_count_o   = err_cnt_q;
    assign stall_count_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ptw_mem_responder.sv
// Bench for ptw_mem_responder: three instances (LATENCY 2, 1, 15) sharing the preload
// port, checked against an array model and cycle-exact latency/bubble expectations.
`timescale 1ns/1ps
module tb_ptw_mem_responder;

    localparam int DEPTH = 1024;
    localparam int NI    = 3;

    logic        clk;
    logic        rst;
    logic        req_valid  [NI];
    logic [31:0] req_addr   [NI];
    logic        req_ready  [NI];
    logic        resp_valid [NI];
    logic        resp_ready [NI];
    logic [31:0] resp_data  [NI];
    logic        resp_err   [NI];
    logic        init_we;
    logic [31:0] init_addr;
    logic [31:0] init_data;
`ifdef PTW_MEM_STATS_EN
    logic [15:0] req_cnt    [NI];
    logic [15:0] err_cnt    [NI];
    logic [15:0] stall_cnt  [NI];
`endif

    logic [31:0] ref_mem [DEPTH];
    int          exp_req   [NI];
    int          exp_err   [NI];
    int          exp_stall [NI];
    int          n_cmp;
    int          n_mis;

    function automatic int lat_of(input int i);
        return (i == 0) ? 2 : (i == 1) ? 1 : 15;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int L = (g == 0) ? 2 : (g == 1) ? 1 : 15;
        ptw_mem_responder #(.DEPTH(DEPTH), .LATENCY(L)) u_dut (
            .clk              (clk),
            .rst              (rst),
            .mem_req_valid_i  (req_valid[g]),
            .mem_req_ready_o  (req_ready[g]),
            .mem_addr_i       (req_addr[g]),
            .mem_resp_valid_o (resp_valid[g]),
            .mem_resp_ready_i (resp_ready[g]),
            .mem_data_o       (resp_data[g]),
            .mem_err_o        (resp_err[g]),
            .init_we_i        (init_we),
            .init_addr_i      (init_addr),
            .init_data_i      (init_data)
`ifdef PTW_MEM_STATS_EN
            ,
            .req_count_o      (req_cnt[g]),
            .err_count_o      (err_cnt[g]),
            .stall_count_o    (stall_cnt[g])
`endif
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_stats(input int i);
`ifdef PTW_MEM_STATS_EN
        check($sformatf("req_count_i%0d", i), 32'(req_cnt[i]), 32'(exp_req[i]));
        check($sformatf("err_count_i%0d", i), 32'(err_cnt[i]), 32'(exp_err[i]));
        check($sformatf("stall_count_i%0d", i), 32'(stall_cnt[i]), 32'(exp_stall[i]));
`else
        check($sformatf("idle_valid_i%0d", i), 32'(resp_valid[i]), 32'd0);
`endif
    endtask

    // Called at a negedge; drives one preload write across the next posedge.
    task automatic init_write(input logic [31:0] idx, input logic [31:0] d);
        init_we   = 1'b1;
        init_addr = {idx[29:0], 2'(($urandom_range(0, 3)))};
        init_data = d;
        @(negedge clk);
        init_we = 1'b0;
        if (idx < DEPTH && idx[31:30] == 2'b00) ref_mem[idx] = d;
    endtask

    // One request on instance i. wf: preload the same word on the read cycle.
    // rw: preload the same word while the response is held. Ends on the negedge
    // where ready should be back, so consecutive calls are back-to-back.
    task automatic do_req(input int i, input logic [31:0] addr, input int hold,
                          input bit wf, input logic [31:0] wf_data, input bit rw);
        int          L;
        int          n;
        logic [31:0] idx;
        logic [31:0] exp_d;
        logic        exp_e;
        L   = lat_of(i);
        idx = {2'b00, addr[31:2]};
        n   = 0;
        while (req_ready[i] !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("req_ready_i%0d", i), 32'(req_ready[i]), 32'd1);
        req_valid[i]  = 1'b1;
        req_addr[i]   = addr;
        resp_ready[i] = (hold == 0);
        if (wf && L == 1) begin
            init_we   = 1'b1;
            init_addr = addr;
            init_data = wf_data;
        end
        @(negedge clk);
        exp_req[i]++;
        req_valid[i] = 1'b0;
        req_addr[i]  = $urandom;
        if (wf && L == 1) begin
            init_we = 1'b0;
            if (idx < DEPTH) ref_mem[idx] = wf_data;
        end
        for (int k = 1; k < L; k++) begin
            check($sformatf("wait_valid_i%0d_k%0d", i, k), 32'(resp_valid[i]), 32'd0);
            check($sformatf("wait_ready_i%0d_k%0d", i, k), 32'(req_ready[i]), 32'd0);
            if (wf && k == L - 1) begin
                init_we   = 1'b1;
                init_addr = addr;
                init_data = wf_data;
            end
            @(negedge clk);
            if (wf && k == L - 1) begin
                init_we = 1'b0;
                if (idx < DEPTH) ref_mem[idx] = wf_data;
            end
        end
        exp_e = (idx >= DEPTH);
        exp_d = exp_e ? 32'd0 : ref_mem[idx];
        check($sformatf("resp_valid_i%0d", i), 32'(resp_valid[i]), 32'd1);
        check($sformatf("resp_data_i%0d_a%h", i, addr), resp_data[i], exp_d);
        check($sformatf("resp_err_i%0d_a%h", i, addr), 32'(resp_err[i]), 32'(exp_e));
        for (int h = 0; h < hold; h++) begin
            check($sformatf("hold_valid_i%0d_h%0d", i, h), 32'(resp_valid[i]), 32'd1);
            check($sformatf("hold_data_i%0d_h%0d", i, h), resp_data[i], exp_d);
            exp_stall[i]++;
            if (rw && h == 0) begin
                init_we   = 1'b1;
                init_addr = addr;
                init_data = ~exp_d;
            end
            @(negedge clk);
            if (rw && h == 0) begin
                init_we = 1'b0;
                if (idx < DEPTH) ref_mem[idx] = ~exp_d;
            end
        end
        resp_ready[i] = 1'b1;
        if (exp_e) exp_err[i]++;
        @(negedge clk);
        resp_ready[i] = 1'b0;
        check($sformatf("bubble_valid_i%0d", i), 32'(resp_valid[i]), 32'd0);
        check($sformatf("bubble_ready_i%0d", i), 32'(req_ready[i]), 32'd0);
        @(negedge clk);
        check($sformatf("ready_back_i%0d", i), 32'(req_ready[i]), 32'd1);
        check_stats(i);
    endtask

    initial begin
        logic [31:0] a;
        int          inst;
        n_cmp     = 0;
        n_mis     = 0;
        rst       = 1'b1;
        init_we   = 1'b0;
        init_addr = '0;
        init_data = '0;
        for (int i = 0; i < NI; i++) begin
            req_valid[i]  = 1'b0;
            req_addr[i]   = '0;
            resp_ready[i] = 1'b0;
            exp_req[i]    = 0;
            exp_err[i]    = 0;
            exp_stall[i]  = 0;
        end
        repeat (2) @(negedge clk);

        // Reset state, then preload the whole RAM while rst is still high.
        for (int i = 0; i < NI; i++) begin
            check($sformatf("rst_ready_i%0d", i), 32'(req_ready[i]), 32'd0);
            check($sformatf("rst_valid_i%0d", i), 32'(resp_valid[i]), 32'd0);
            check($sformatf("rst_data_i%0d", i), resp_data[i], 32'd0);
            check($sformatf("rst_err_i%0d", i), 32'(resp_err[i]), 32'd0);
        end
        for (int w = 0; w < DEPTH; w++) init_write(32'(w), $urandom);
        init_write(32'd256, 32'h0000_0801);
        init_write(32'd512, 32'h1000_000F);
        init_write(32'd1024, 32'hBAD0_BAD0);
        init_write(32'h3FFF_FC00, 32'hBAD1_BAD1);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("post_rst_ready_i%0d", i), 32'(req_ready[i]), 32'd1);
            check_stats(i);
        end

        // Basic read, held response with a preload during hold, out-of-range.
        do_req(0, 32'h0000_0400, 0, 1'b0, '0, 1'b0);
        do_req(0, 32'h0000_0800, 5, 1'b0, '0, 1'b1);
        do_req(0, 32'h0000_0800, 0, 1'b0, '0, 1'b0);
        do_req(0, 32'h0000_1000, 0, 1'b0, '0, 1'b0);
        do_req(0, 32'hFFFF_FFFC, 1, 1'b0, '0, 1'b0);

        // Write-first on the read cycle, then low address bits ignored.
        do_req(0, 32'h0000_0404, 0, 1'b1, 32'hDEAD_BEEF, 1'b0);
        do_req(0, 32'h0000_0407, 0, 1'b0, '0, 1'b0);
        do_req(0, 32'h0000_0403, 0, 1'b0, '0, 1'b0);

        // Latency extremes, back-to-back over words 0..3.
        for (int w = 0; w < 4; w++) do_req(1, 32'(w * 4), 0, 1'b0, '0, 1'b0);
        for (int w = 0; w < 4; w++) do_req(2, 32'(w * 4), 0, 1'b0, '0, 1'b0);
        do_req(1, 32'h0000_0008, 0, 1'b1, 32'h1234_5678, 1'b0);

        // Asynchronous reset while instance 0 is in WAIT.
        req_valid[0] = 1'b1;
        req_addr[0]  = 32'h0000_0400;
        @(posedge clk);
        #3;
        rst          = 1'b1;
        req_valid[0] = 1'b0;
        #1;
        check("async_rst_valid", 32'(resp_valid[0]), 32'd0);
        check("async_rst_data", resp_data[0], 32'd0);
        check("async_rst_err", 32'(resp_err[0]), 32'd0);
        check("async_rst_ready", 32'(req_ready[0]), 32'd0);
        for (int i = 0; i < NI; i++) begin
            exp_req[i]   = 0;
            exp_err[i]   = 0;
            exp_stall[i] = 0;
        end
        @(negedge clk);
        check("rst_held_ready", 32'(req_ready[0]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_release_ready", 32'(req_ready[0]), 32'd1);
        check_stats(0);
        do_req(0, 32'h0000_0400, 0, 1'b0, '0, 1'b0);

        // Randomized traffic across all three instances.
        for (int r = 0; r < 40; r++) begin
            inst = $urandom_range(0, NI - 1);
            if ($urandom_range(0, 7) == 0) a = 32'(DEPTH * 4) + ($urandom & 32'h0FFF_FFFF);
            else a = {20'd0, 10'($urandom_range(0, DEPTH - 1)), 2'($urandom_range(0, 3))};
            do_req(inst, a, $urandom_range(0, 3), ($urandom_range(0, 3) == 0), $urandom,
                   ($urandom_range(0, 3) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
